// File: rtl/alu_datapath_pkg.sv
// Shared types and encodings for the alu_datapath execution slice: opcodes, B-operand
// selects, PSR bit positions, and the control-word / writeback payload structs.
package alu_datapath_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned BSEL_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_CMP = 4'h6,
    OP_MOV = 4'h7
  } opcode_e;

  typedef enum logic [BSEL_W-1:0] {
    B_SEL_REG  = 2'b00,
    B_SEL_IMM  = 2'b01,
    B_SEL_PSR  = 2'b10,
    B_SEL_ZERO = 2'b11
  } b_sel_e;

  // PSR layout is {N,Z,F,L,C}, MSB first
  localparam int unsigned PSR_N = 4;
  localparam int unsigned PSR_Z = 3;
  localparam int unsigned PSR_F = 2;
  localparam int unsigned PSR_L = 1;
  localparam int unsigned PSR_C = 0;

  typedef struct packed {
    logic [NREGS-1:0]  reg_en;
    logic [IDX_W-1:0]  reg_a;
    logic [IDX_W-1:0]  reg_b;
    logic [WIDTH-1:0]  imm;
    logic [BSEL_W-1:0] b_sel;
    logic [OP_W-1:0]   opcode;
    logic              flag_en;
  } ctrl_t;

  typedef struct packed {
    logic [NREGS-1:0]  en;
    logic [WIDTH-1:0]  data;
    logic [FLAG_W-1:0] flags;
    logic              flag_v;
  } wb_t;

  // Unassigned encodings behave as NOP so a stray opcode can never corrupt state
  function automatic logic op_is_nop(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_MOV: op_is_nop = 1'b0;
      default:                                               op_is_nop = 1'b1;
    endcase
  endfunction

  function automatic logic op_writes_rf(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: op_writes_rf = 1'b1;
      default:                                       op_writes_rf = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_datapath_alu16.sv
// alu16: combinational {opcode, A, B} -> {result, flags {N,Z,F,L,C}}.
module alu16
  import alu_datapath_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  output logic [WIDTH-1:0]  result_o,
  output logic [FLAG_W-1:0] flags_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             less;

  always_comb begin
    sum   = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i);
    diff  = (WIDTH+1)'(a_i) - (WIDTH+1)'(b_i);
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    less  = 1'b0;
    case (opcode_e'(op_i))
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      // diff[WIDTH] is the borrow, i.e. A < B unsigned
      OP_SUB, OP_CMP: begin
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        less  = diff[WIDTH];
        ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_MOV:  res = b_i;
      default: res = '0;
    endcase
  end

  always_comb begin
    flags_o = '0;
    if (!op_is_nop(op_i)) begin
      flags_o[PSR_N] = res[WIDTH-1];
      flags_o[PSR_Z] = (res == '0);
      flags_o[PSR_F] = ovf;
      flags_o[PSR_L] = less;
      flags_o[PSR_C] = carry;
    end
  end

  assign result_o = res;

endmodule

// File: rtl/alu_datapath.sv
// Execution datapath: 16x16 register file, B-operand mux, ALU and 5-bit PSR with writeback.
// Define DP_PIPE_EN to add a forwarding writeback stage (commit latency 2 instead of 1).
module alu_datapath
  import alu_datapath_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NREGS-1:0]   reg_en,
  input  logic [IDX_W-1:0]   reg_a,
  input  logic [IDX_W-1:0]   reg_b,
  input  logic [WIDTH-1:0]   imm,
  input  logic [BSEL_W-1:0]  b_sel,
  input  logic [OP_W-1:0]    opcode,
  input  logic               flag_en,
  output logic [WIDTH-1:0]   result,
  output logic [FLAG_W-1:0]  psr,
  input  logic [IDX_W-1:0]   dbg_sel,
  output logic [WIDTH-1:0]   dbg_data
);

  ctrl_t             ctrl;
  logic [WIDTH-1:0]  rf_q [NREGS];
  logic [WIDTH-1:0]  rf_d [NREGS];
  logic [FLAG_W-1:0] psr_q;
  logic [FLAG_W-1:0] psr_d;
  logic [WIDTH-1:0]  a_op;
  logic [WIDTH-1:0]  rf_b;
  logic [WIDTH-1:0]  b_op;
  logic [FLAG_W-1:0] psr_src;
  logic [WIDTH-1:0]  alu_res;
  logic [FLAG_W-1:0] alu_flags;
  logic [NREGS-1:0]  wr_en;
  logic              flag_ld;
  wb_t               commit;

  assign ctrl = '{reg_en: reg_en, reg_a: reg_a, reg_b: reg_b, imm: imm,
                  b_sel: b_sel, opcode: opcode, flag_en: flag_en};

  // CMP and NOP never write the register file; NOP also never touches the PSR
  assign wr_en   = op_writes_rf(ctrl.opcode) ? ctrl.reg_en : '0;
  assign flag_ld = ctrl.flag_en && !op_is_nop(ctrl.opcode);

`ifdef DP_PIPE_EN
  wb_t wb_q;
  wb_t wb_d;

  assign wb_d = '{en: wr_en, data: alu_res, flags: alu_flags, flag_v: flag_ld};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  // Forward the pending writeback so dependent back-to-back ops see the same values as the 1-stage build
  assign a_op    = wb_q.en[ctrl.reg_a] ? wb_q.data  : rf_q[ctrl.reg_a];
  assign rf_b    = wb_q.en[ctrl.reg_b] ? wb_q.data  : rf_q[ctrl.reg_b];
  assign psr_src = wb_q.flag_v         ? wb_q.flags : psr_q;
  assign commit  = wb_q;
`else
  assign a_op    = rf_q[ctrl.reg_a];
  assign rf_b    = rf_q[ctrl.reg_b];
  assign psr_src = psr_q;
  assign commit  = '{en: wr_en, data: alu_res, flags: alu_flags, flag_v: flag_ld};
`endif

  always_comb begin
    b_op = '0;
    case (b_sel_e'(ctrl.b_sel))
      B_SEL_REG:  b_op = rf_b;
      B_SEL_IMM:  b_op = ctrl.imm;
      B_SEL_PSR:  b_op = WIDTH'(psr_src);
      B_SEL_ZERO: b_op = '0;
    endcase
  end

  alu16 u_alu (
    .op_i     (ctrl.opcode),
    .a_i      (a_op),
    .b_i      (b_op),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  assign result = rst ? '0 : alu_res;

  // Commit: multi-hot enables load every selected register with the same value
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      rf_d[i] = commit.en[i] ? commit.data : rf_q[i];
    end
    psr_d = commit.flag_v ? commit.flags : psr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
      psr_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
      psr_q <= psr_d;
    end
  end

  assign psr      = psr_q;
  assign dbg_data = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: vector table plus back-to-back and mid-sequence reset cases.
// Builds with or without DP_PIPE_EN; committed-state checks wait for the build's commit latency.
module tb_alu_datapath;
  import alu_datapath_pkg::*;

`ifdef DP_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] reg_en;
  logic [3:0]  reg_a;
  logic [3:0]  reg_b;
  logic [15:0] imm;
  logic [1:0]  b_sel;
  logic [3:0]  opcode;
  logic        flag_en;
  logic [15:0] result;
  logic [4:0]  psr;
  logic [3:0]  dbg_sel;
  logic [15:0] dbg_data;

  int n_tests;
  int n_fail;

  alu_datapath dut (
    .clk      (clk),
    .rst      (rst),
    .reg_en   (reg_en),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .imm      (imm),
    .b_sel    (b_sel),
    .opcode   (opcode),
    .flag_en  (flag_en),
    .result   (result),
    .psr      (psr),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] en;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] imm;
    logic [1:0]  bsel;
    logic [3:0]  op;
    logic        fl;
    logic [15:0] exp_res;
    logic [3:0]  chk;
    logic [15:0] exp_reg;
    logic [4:0]  exp_psr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] en, input logic [3:0] a, input logic [3:0] b,
                              input logic [15:0] im, input logic [1:0] bs, input logic [3:0] op,
                              input logic fl, input logic [15:0] er, input logic [3:0] ck,
                              input logic [15:0] eg, input logic [4:0] ep);
    vec_t v;
    v.en = en; v.a = a; v.b = b; v.imm = im; v.bsel = bs; v.op = op; v.fl = fl;
    v.exp_res = er; v.chk = ck; v.exp_reg = eg; v.exp_psr = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] en, input logic [3:0] a, input logic [3:0] b,
                       input logic [15:0] im, input logic [1:0] bs, input logic [3:0] op,
                       input logic fl);
    reg_en = en; reg_a = a; reg_b = b; imm = im; b_sel = bs; opcode = op; flag_en = fl;
  endtask

  task automatic idle();
    drive(16'h0000, 4'd0, 4'd0, 16'h0000, B_SEL_REG, OP_NOP, 1'b0);
  endtask

  // From the negedge after an op's edge: idle until that op has committed, then land on a negedge
  task automatic drain();
    idle();
    repeat (LAT - 1) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), dbg_data, 16'h0000);
    end
    chk($sformatf("%s_psr", tag), 16'(psr), 16'h0000);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    dbg_sel = 4'd0;

    // Columns: en, a, b, imm, bsel, op, flag_en, exp result, check reg, exp reg, exp psr
    vecs.push_back(mk(16'h0002, 0, 0, 16'hFFFF, B_SEL_IMM,  OP_ADD, 0, 16'hFFFF,  1, 16'hFFFF, 5'h00));
    vecs.push_back(mk(16'h0004, 0, 0, 16'h0002, B_SEL_IMM,  OP_ADD, 0, 16'h0002,  2, 16'h0002, 5'h00));
    vecs.push_back(mk(16'h0080, 1, 2, 16'h0000, B_SEL_REG,  OP_ADD, 1, 16'h0001,  7, 16'h0001, 5'h01));
    vecs.push_back(mk(16'h0100, 0, 0, 16'h0000, B_SEL_PSR,  OP_ADD, 0, 16'h0001,  8, 16'h0001, 5'h01));
    vecs.push_back(mk(16'h0001, 0, 0, 16'h7FFF, B_SEL_IMM,  OP_ADD, 0, 16'h7FFF,  0, 16'h7FFF, 5'h01));
    vecs.push_back(mk(16'h0004, 0, 0, 16'h0001, B_SEL_IMM,  OP_MOV, 0, 16'h0001,  2, 16'h0001, 5'h01));
    vecs.push_back(mk(16'h0008, 0, 2, 16'h0000, B_SEL_REG,  OP_ADD, 1, 16'h8000,  3, 16'h8000, 5'h14));
    vecs.push_back(mk(16'h0001, 0, 0, 16'h8000, B_SEL_IMM,  OP_MOV, 0, 16'h8000,  0, 16'h8000, 5'h14));
    vecs.push_back(mk(16'h0010, 0, 2, 16'h0000, B_SEL_REG,  OP_SUB, 1, 16'h7FFF,  4, 16'h7FFF, 5'h04));
    vecs.push_back(mk(16'hFFFF, 2, 0, 16'h0000, B_SEL_REG,  OP_CMP, 1, 16'h8001,  2, 16'h0001, 5'h17));
    vecs.push_back(mk(16'hFFFF, 0, 0, 16'h1234, B_SEL_IMM,  OP_NOP, 1, 16'h0000,  0, 16'h8000, 5'h17));
    vecs.push_back(mk(16'h0006, 5, 0, 16'h0005, B_SEL_IMM,  OP_ADD, 0, 16'h0005,  1, 16'h0005, 5'h17));
    vecs.push_back(mk(16'h0200, 0, 0, 16'hFFFF, B_SEL_IMM,  OP_AND, 1, 16'h8000,  9, 16'h8000, 5'h10));
    vecs.push_back(mk(16'h0400, 4, 0, 16'h7FFF, B_SEL_IMM,  OP_XOR, 1, 16'h0000, 10, 16'h0000, 5'h08));
    vecs.push_back(mk(16'h0800, 3, 4, 16'h0000, B_SEL_REG,  OP_OR,  1, 16'hFFFF, 11, 16'hFFFF, 5'h10));
    vecs.push_back(mk(16'h1000, 1, 1, 16'h0000, B_SEL_REG,  OP_SUB, 1, 16'h0000, 12, 16'h0000, 5'h08));
    vecs.push_back(mk(16'h2000, 3, 0, 16'h0000, B_SEL_ZERO, OP_ADD, 0, 16'h8000, 13, 16'h8000, 5'h08));
    vecs.push_back(mk(16'h0002, 1, 0, 16'h0001, B_SEL_IMM,  OP_ADD, 0, 16'h0006,  1, 16'h0006, 5'h08));

    // Reset: ALU would produce 0005 but result must read 0 while rst is held
    rst = 1'b1;
    drive(16'hFFFF, 4'd0, 4'd0, 16'h0005, B_SEL_IMM, OP_ADD, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("reset_result", result, 16'h0000);
    check_all_zero("reset");
    idle();
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].en, vecs[k].a, vecs[k].b, vecs[k].imm, vecs[k].bsel, vecs[k].op, vecs[k].fl);
      dbg_sel = vecs[k].chk;
      #1;
      chk($sformatf("v%0d_result", k), result, vecs[k].exp_res);
      @(posedge clk);
      @(negedge clk);
      drain();
      #1;
      chk($sformatf("v%0d_r%0d", k, vecs[k].chk), dbg_data, vecs[k].exp_reg);
      chk($sformatf("v%0d_psr", k), 16'(psr), 16'(vecs[k].exp_psr));
    end

    // Multi-hot write also landed in r2
    dbg_sel = 4'd2;
    #1;
    chk("multihot_r2", dbg_data, 16'h0005);

    // Back-to-back dependent ops: each result relies on the previous op's register/flags
    @(negedge clk);
    drive(16'h4000, 4'd1, 4'd0, 16'h0003, B_SEL_IMM, OP_ADD, 1'b1);
    #1;
    chk("b2b_add_result", result, 16'h0009);
    @(posedge clk);
    @(negedge clk);
    drive(16'h8000, 4'd14, 4'd0, 16'h000A, B_SEL_IMM, OP_SUB, 1'b1);
    #1;
    chk("b2b_sub_result", result, 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    drive(16'h2000, 4'd0, 4'd0, 16'h0000, B_SEL_PSR, OP_MOV, 1'b0);
    #1;
    chk("b2b_movpsr_result", result, 16'h0013);
    @(posedge clk);
    @(negedge clk);
    drain();
    dbg_sel = 4'd14; #1;
    chk("b2b_r14", dbg_data, 16'h0009);
    dbg_sel = 4'd15; #1;
    chk("b2b_r15", dbg_data, 16'hFFFF);
    dbg_sel = 4'd13; #1;
    chk("b2b_r13", dbg_data, 16'h0013);
    chk("b2b_psr", 16'(psr), 16'h0013);

    // Reset mid-sequence with a write (and, when pipelined, a pending writeback) in flight
    @(negedge clk);
    drive(16'hFFFF, 4'd0, 4'd0, 16'h0001, B_SEL_IMM, OP_ADD, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_result", result, 16'h0000);
    check_all_zero("midrst");
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_all_zero("postrst");

    // Datapath recovers after reset
    drive(16'h0020, 4'd0, 4'd0, 16'h0042, B_SEL_IMM, OP_ADD, 1'b0);
    dbg_sel = 4'd5;
    @(posedge clk);
    @(negedge clk);
    drain();
    #1;
    chk("recover_r5", dbg_data, 16'h0042);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
